// File: rtl/sens_bram_pkg.sv
// Shared types and default geometry for the ToF sensor-data BRAM arbiter.
// Address layout is {sens, row, col}, 3 bits each.
package sens_bram_pkg;

  localparam int SENS_ADDR_W   = 9;
  localparam int SENS_DATA_W   = 16;
  localparam int SENS_RD_LAT   = 1;
  localparam int SENS_WR_BURST = 8;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_WR   = 2'd1,
    TAG_FSM  = 2'd2,
    TAG_AXI  = 2'd3
  } req_tag_t;

  typedef struct packed {
    logic [2:0] sens;
    logic [2:0] row;
    logic [2:0] col;
  } sens_addr_t;

  function automatic logic [SENS_ADDR_W-1:0] pack_sens_addr(input logic [2:0] sens,
                                                            input logic [2:0] row,
                                                            input logic [2:0] col);
    sens_addr_t a;
    a.sens = sens;
    a.row  = row;
    a.col  = col;
    return a;
  endfunction

endpackage

// File: rtl/sens_bram_rd_tag_pipe.sv
// Carries the issuing requester's tag alongside the BRAM read latency; decodes rvalid.
// Latency RD_LAT cycles; no backpressure, one tag accepted every cycle.
module sens_bram_rd_tag_pipe
  import sens_bram_pkg::*;
#(
  parameter int RD_LAT = SENS_RD_LAT
) (
  input  logic     clk,
  input  logic     rst,
  input  req_tag_t issue_tag,
  output logic     fsm_rvalid,
  output logic     axi_rvalid
);

  req_tag_t tag_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= TAG_NONE;
    end else begin
      tag_q[0] <= issue_tag;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Gating with rst keeps a read issued just before reset from surfacing.
  assign fsm_rvalid = !rst && (tag_q[RD_LAT-1] == TAG_FSM);
  assign axi_rvalid = !rst && (tag_q[RD_LAT-1] == TAG_AXI);

endmodule

// File: rtl/sens_bram_arbiter.sv
// Single-port sensor BRAM arbiter: writer first with a bounded burst, readers round-robin.
// Grant is same-cycle combinational; read data returns RD_LAT cycles after grant, no stalls.
module sens_bram_arbiter
  import sens_bram_pkg::*;
#(
  parameter int ADDR_W   = SENS_ADDR_W,
  parameter int DATA_W   = SENS_DATA_W,
  parameter int RD_LAT   = SENS_RD_LAT,
  parameter int WR_BURST = SENS_WR_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              fsm_req,
  input  logic [ADDR_W-1:0] fsm_addr,
  output logic              fsm_gnt,
  output logic              fsm_rvalid,
  input  logic              axi_req,
  input  logic [ADDR_W-1:0] axi_addr,
  output logic              axi_gnt,
  output logic              axi_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  localparam int               CNT_W   = $clog2(WR_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WR_BURST);

  logic [CNT_W-1:0] wr_cnt;
  req_tag_t         rr_last;
  req_tag_t         issue_tag;
  logic             rd_pend;
  logic             wr_hold_off;
  logic             fsm_turn;

  // Grant decode
  always_comb begin
    wr_gnt      = 1'b0;
    fsm_gnt     = 1'b0;
    axi_gnt     = 1'b0;
    rd_pend     = fsm_req | axi_req;
    wr_hold_off = (wr_cnt == CNT_MAX) && rd_pend;
    // On a reader tie the one not served last goes first.
    fsm_turn    = !axi_req || (rr_last != TAG_FSM);
    if (!rst) begin
      if (wr_req && !wr_hold_off) begin
        wr_gnt = 1'b1;
      end else if (fsm_req && fsm_turn) begin
        fsm_gnt = 1'b1;
      end else if (axi_req) begin
        axi_gnt = 1'b1;
      end
    end
  end

  // BRAM port mux; idle cycles drive zeros
  always_comb begin
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_wdata = '0;
    issue_tag  = TAG_NONE;
    if (wr_gnt) begin
      bram_en    = 1'b1;
      bram_we    = 1'b1;
      bram_addr  = wr_addr;
      bram_wdata = wr_data;
      issue_tag  = TAG_WR;
    end else if (fsm_gnt) begin
      bram_en   = 1'b1;
      bram_addr = fsm_addr;
      issue_tag = TAG_FSM;
    end else if (axi_gnt) begin
      bram_en   = 1'b1;
      bram_addr = axi_addr;
      issue_tag = TAG_AXI;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      rr_last <= TAG_AXI;
    end else begin
      if (fsm_gnt) begin
        rr_last <= TAG_FSM;
      end else if (axi_gnt) begin
        rr_last <= TAG_AXI;
      end
      // Writer streak resets when a reader is served or the writer goes idle.
      if (fsm_gnt || axi_gnt || !wr_req) begin
        wr_cnt <= '0;
      end else if (wr_gnt && (wr_cnt < CNT_MAX)) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  sens_bram_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .issue_tag  (issue_tag),
    .fsm_rvalid (fsm_rvalid),
    .axi_rvalid (axi_rvalid)
  );

  assign rdata = bram_rdata;

  gnt_onehot_a: assert property (@(posedge clk) disable iff (rst)
    $onehot0({wr_gnt, fsm_gnt, axi_gnt}));

endmodule
